switch_debounce: RTL and testbench

//   Conditions the raw board DIP switches before they reach the single-cycle CPU's iSwitch input.

---
 rtl/switch_debounce.sv | 109 ++++++++++
 tb/tb_switch_debounce.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Switch conditioner: 2-FF synchronizer per bit, a shared sampling-tick
// prescaler, and a per-bit stability filter that accepts a new level after
// STABLE_TICKS consecutive tick samples differing from the current output.
//
// Ports
//   iClk      system clock
//   iRst      asynchronous active-high reset
//   iSwitch   raw asynchronous switch levels
//   oSwitch   debounced levels
//   oRise     one-cycle pulse per bit on an accepted 0->1
//   oFall     one-cycle pulse per bit on an accepted 1->0
//   oChanged  one-cycle pulse when any bit is accepted
//   oTick     one-cycle sample-tick pulse
module switch_debounce #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned TICK_DIV     = 1_000_000,
  parameter int unsigned STABLE_TICKS = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iSwitch,
  output logic [WIDTH-1:0] oSwitch,
  output logic [WIDTH-1:0] oRise,
  output logic [WIDTH-1:0] oFall,
  output logic             oChanged,
  output logic             oTick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick_q, tick_d;
  logic [WIDTH-1:0]        s1_q, s2_q;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]        sw_q, sw_d;
  logic [WIDTH-1:0]        rise_q, rise_d;
  logic [WIDTH-1:0]        fall_q, fall_d;
  logic                    chg_q, chg_d;

  // Prescaler: wraps at TICK_DIV-1; the tick is registered one edge later.
  always_comb begin
    presc_d = presc_q + PW'(1);
    tick_d  = 1'b0;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      tick_d  = 1'b1;
    end
  end

  // Per-bit filter, only advanced on edges where the tick is high.
  // Strobes default to 0 so they last exactly one cycle.
  always_comb begin
    sw_d   = sw_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    if (tick_q) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s2_q[i] == sw_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          sw_d[i]   = s2_q[i];
          cnt_d[i]  = '0;
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    chg_d = |(rise_d | fall_d);
  end

  // State registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      sw_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      chg_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      s1_q    <= iSwitch;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      chg_q   <= chg_d;
    end
  end

  assign oSwitch  = sw_q;
  assign oRise    = rise_q;
  assign oFall    = fall_q;
  assign oChanged = chg_q;
  assign oTick    = tick_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed scenarios plus random switch activity,
// checked every cycle against a sample-history reference model.
module tb_switch_debounce;

  localparam int TD = 4;
  localparam int ST = 3;
  localparam int W  = 8;

  logic         iClk = 1'b0;
  logic         iRst;
  logic [W-1:0] iSwitch;
  logic [W-1:0] oSwitch, oRise, oFall;
  logic         oChanged, oTick;

  int total = 0;
  int bad   = 0;

  switch_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .iClk(iClk), .iRst(iRst), .iSwitch(iSwitch), .oSwitch(oSwitch),
    .oRise(oRise), .oFall(oFall), .oChanged(oChanged), .oTick(oTick)
  );

  always #5 iClk = ~iClk;

  // Reference model: edges since reset release, input seen at each edge,
  // and the list of values the filter has sampled at ticks.
  int           m_e;
  logic [W-1:0] in_hist[$];
  logic [W-1:0] smp[$];
  logic [W-1:0] m_sw, m_rise, m_fall;
  logic         m_chg, m_tick;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_e = 0;
    in_hist.delete();
    smp.delete();
    m_sw = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0; m_tick = 1'b0;
  endtask

  task automatic check_all();
    chk("oSwitch",  oSwitch,      m_sw);
    chk("oRise",    oRise,        m_rise);
    chk("oFall",    oFall,        m_fall);
    chk("oChanged", W'(oChanged), W'(m_chg));
    chk("oTick",    W'(oTick),    W'(m_tick));
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic step();
    logic [W-1:0] s2;
    logic [W-1:0] nsw;
    bit           all_diff;
    @(posedge iClk);
    m_e++;
    in_hist.push_back(iSwitch);
    m_rise = '0;
    m_fall = '0;
    nsw    = m_sw;
    // Filter evaluates when the tick was high before this edge; the value it
    // sees is the input from two edges earlier (0 right after reset).
    if (m_e > 1 && ((m_e - 1) % TD) == 0) begin
      s2 = (m_e >= 3) ? in_hist[m_e - 3] : '0;
      smp.push_back(s2);
      if (smp.size() >= ST) begin
        for (int b = 0; b < W; b++) begin
          all_diff = 1'b1;
          for (int k = 0; k < ST; k++)
            if (smp[smp.size() - 1 - k][b] == m_sw[b]) all_diff = 1'b0;
          if (all_diff) begin
            nsw[b]    = ~m_sw[b];
            m_rise[b] = ~m_sw[b];
            m_fall[b] = m_sw[b];
          end
        end
      end
    end
    m_sw   = nsw;
    m_chg  = |(m_rise | m_fall);
    m_tick = ((m_e % TD) == 0);
    #1;
    check_all();
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  // Asserts reset asynchronously just after an edge, holds, then releases.
  task automatic do_reset();
    iRst = 1'b1;
    model_reset();
    #1;
    check_all();
    repeat (3) @(posedge iClk);
    #1;
    check_all();
    iRst = 1'b0;
  endtask

  initial begin
    iRst    = 1'b1;
    iSwitch = '0;
    model_reset();
    #2;
    check_all();

    // 1: reset release, quiet switches
    do_reset();
    hold(40);
    chk("s1_idle", oSwitch, 8'h00);

    // 2: step to A5
    iSwitch = 8'hA5;
    hold(30);
    chk("s2_a5", oSwitch, 8'hA5);

    // 3: bit0 falls, then bounces 1,0,1 across ticks before settling high
    iSwitch = 8'hA4;
    hold(25);
    chk("s3_low", oSwitch, 8'hA4);
    iSwitch = 8'hA5; hold(TD);
    iSwitch = 8'hA4; hold(TD);
    iSwitch = 8'hA5; hold(30);
    chk("s3_settle", oSwitch, 8'hA5);

    // 4: all bits flip at once
    iSwitch = 8'h5A;
    hold(25);
    chk("s4_5a", oSwitch, 8'h5A);

    // 5: reset in the middle of a count
    iSwitch = 8'hFF;
    hold(2 * TD + 2);
    do_reset();
    hold(30);
    chk("s5_ff", oSwitch, 8'hFF);

    // 6: short glitch on bit7 placed between sample points
    iSwitch = 8'h00;
    hold(25);
    while ((m_e % TD) != 3) step();
    iSwitch = 8'h80;
    hold(2);
    iSwitch = 8'h00;
    hold(20);
    chk("s6_glitch", oSwitch, 8'h00);

    // Random activity with random hold lengths, including short bounces
    for (int n = 0; n < 150; n++) begin
      if (($urandom % 4) == 0)
        iSwitch = iSwitch ^ W'(1 << ($urandom % W));
      else
        iSwitch = W'($urandom);
      hold(1 + int'($urandom % 20));
      if (n == 75) begin
        do_reset();
        hold(5);
      end
    end
    iSwitch = 8'h3C;
    hold(30);
    chk("rand_final", oSwitch, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
